fact_arbiter: RTL and testbench
===============================

FACT_ARBITER -- requirements
Module: fact_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023, maximum cycles fact_go may stay high awaiting fact_done/fact_error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0_valid, req1_valid  input  1  requester i has a job.
REQ-005 req0_n, req1_n  input  32  operand for requester i.
REQ-006 req0_ready, req1_ready  output  1  job accepted when valid&ready.
REQ-007 rsp0_valid, rsp1_valid  output  1  result for requester i pending.
REQ-008 rsp0_ready, rsp1_ready  input  1  requester i consumes result.
REQ-009 rsp_product  output  32  result shared by both requesters; meaningful only with a rsp_valid.
REQ-010 rsp_error  output  1  engine error or timeout for the pending result.
REQ-011 rsp_timeout  output  1  pending result terminated by timeout.
REQ-012 fact_go  output  1  go to factorial engine.
REQ-013 fact_n  output  32  operand to engine.
REQ-014 fact_done, fact_error  input  1  engine completion/error, level, held until fact_go low.
REQ-015 fact_product  input  32  engine result.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 States SHALL be IDLE, RUN, RESP, DRAIN.
REQ-018 IDLE: req_ready SHALL be high only for the granted requester; grant combinational from req_valid and last_grant.
REQ-019 Arbitration SHALL be round-robin: sole requester wins; both valid -> the one not equal to last_grant wins.
REQ-020 On accept (cycle k): latch owner, latch operand into fact_n, last_grant<=owner, timer<=0, state->RUN; fact_go high from cycle k+1.
REQ-021 fact_n SHALL remain stable from accept until return to IDLE.
REQ-022 RUN: fact_go high; timer increments per cycle, saturating.
REQ-023 RUN, fact_done or fact_error sampled high: latch fact_product, rsp_error<=fact_error, rsp_timeout<=0, state->RESP.
REQ-024 RUN, timer reaches TIMEOUT with neither input high: rsp_product<=0, rsp_error<=1, rsp_timeout<=1, state->RESP.
REQ-025 fact_done and fact_error high in same cycle: error takes precedence (rsp_error=1, product still latched).
REQ-026 RESP: fact_go low; rsp_valid high only for owner; other requester's rsp_valid and both req_ready low.
REQ-027 RESP, owner rsp_ready high: state->DRAIN; rsp_valid drops next cycle.
REQ-028 DRAIN: fact_go low; state->IDLE when fact_done=0 and fact_error=0 sampled; no new accept before IDLE.
REQ-029 req_valid SHALL be ignored outside IDLE; a requester holding valid through RESP/DRAIN is served only by arbitration in IDLE.
REQ-030 rsp_product/rsp_error/rsp_timeout SHALL hold value from RESP entry until next RESP entry.
REQ-031 fact_go, req_ready, rsp_valid, busy SHALL be decoded from registered state only (no combinational path from fact_* inputs).

Reset
REQ-032 reset low SHALL immediately force state IDLE, fact_go=0, fact_n=0, rsp_valid=0, rsp_product=0, rsp_error=0, rsp_timeout=0, busy=0, timer=0, last_grant=1 (requester 0 wins first tie).
REQ-033 reset low mid-RUN SHALL abandon the job with no response; after release, the first tie-break SHALL favour requester 0.
REQ-034 req_ready SHALL be 0 while reset low.

Verification
REQ-035 req0 n=5, engine model done after 6 cycles -> fact_go rises cycle after accept, rsp0_valid, rsp_product=120, rsp_error=0.
REQ-036 req0 and req1 valid together from reset, n=3/n=4 -> req0 served first (6), then req1 (24); next tie goes to req0.
REQ-037 engine asserts fact_error for n=13 -> rsp_error=1, rsp_timeout=0, owner rsp_valid only.
REQ-038 TIMEOUT=8, engine never responds -> rsp_error=1, rsp_timeout=1, rsp_product=0 after 8 RUN cycles; arbiter returns to IDLE after rsp_ready.
REQ-039 rsp_ready held low 20 cycles with req1 valid -> req1_ready stays 0, fact_go stays 0, result stable; DRAIN waits while fact_done still high.
REQ-040 reset pulsed low during RUN -> fact_go and busy drop same cycle asynchronously, no rsp_valid, next tie grants req0.

Source files
------------

// File: rtl/fact_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and a shared factorial engine.
// master is the arbiter's view; slave is the requester/engine side.
interface fact_arbiter_if;
   logic        req0_valid;
   logic        req1_valid;
   logic [31:0] req0_n;
   logic [31:0] req1_n;
   logic        req0_ready;
   logic        req1_ready;
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic        rsp0_ready;
   logic        rsp1_ready;
   logic [31:0] rsp_product;
   logic        rsp_error;
   logic        rsp_timeout;
   logic        fact_go;
   logic [31:0] fact_n;
   logic        fact_done;
   logic        fact_error;
   logic [31:0] fact_product;
   logic        busy;

   modport master (
      input  req0_valid, req1_valid, req0_n, req1_n, rsp0_ready, rsp1_ready,
             fact_done, fact_error, fact_product,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_product, rsp_error,
             rsp_timeout, fact_go, fact_n, busy
   );

   modport slave (
      output req0_valid, req1_valid, req0_n, req1_n, rsp0_ready, rsp1_ready,
             fact_done, fact_error, fact_product,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_product, rsp_error,
             rsp_timeout, fact_go, fact_n, busy
   );
endinterface

// File: rtl/fact_arbiter.sv
// Round-robin arbiter sharing one factorial engine between two requesters, with a
// watchdog that terminates a job the engine never answers.
module fact_arbiter #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic           clk,
   input  logic           reset,
   fact_arbiter_if.master bus
);

   localparam int unsigned     TimerW    = $clog2(TIMEOUT + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StRun, StResp, StDrain} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [31:0]       fact_n_q, fact_n_d;
   logic [31:0]       product_q, product_d;
   logic              error_q, error_d;
   logic              timeout_q, timeout_d;
   logic              grant0, grant1;

   // On a tie the requester that was not served last wins.
   assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
   assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      fact_n_d     = fact_n_q;
      product_d    = product_q;
      error_d      = error_q;
      timeout_d    = timeout_q;
      unique case (state_q)
         StIdle: begin
            if (grant0 | grant1) begin
               owner_d      = grant1;
               last_grant_d = grant1;
               fact_n_d     = grant1 ? bus.req1_n : bus.req0_n;
               timer_d      = '0;
               state_d      = StRun;
            end
         end
         StRun: begin
            if (timer_q != '1) timer_d = timer_q + 1'b1;
            if (bus.fact_done | bus.fact_error) begin
               product_d = bus.fact_product;
               error_d   = bus.fact_error;
               timeout_d = 1'b0;
               state_d   = StResp;
            end else if (timer_q >= TimerLast) begin
               // fact_go has now been high for TIMEOUT cycles
               product_d = '0;
               error_d   = 1'b1;
               timeout_d = 1'b1;
               state_d   = StResp;
            end
         end
         StResp: begin
            if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = StDrain;
         end
         StDrain: begin
            // Wait for the engine to release its level handshake before the next job.
            if (!bus.fact_done && !bus.fact_error) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         timer_q      <= '0;
         fact_n_q     <= '0;
         product_q    <= '0;
         error_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         fact_n_q     <= fact_n_d;
         product_q    <= product_d;
         error_q      <= error_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.req0_ready  = reset & (state_q == StIdle) & grant0;
   assign bus.req1_ready  = reset & (state_q == StIdle) & grant1;
   assign bus.rsp0_valid  = (state_q == StResp) & ~owner_q;
   assign bus.rsp1_valid  = (state_q == StResp) & owner_q;
   assign bus.fact_go     = (state_q == StRun);
   assign bus.busy        = (state_q != StIdle);
   assign bus.fact_n      = fact_n_q;
   assign bus.rsp_product = product_q;
   assign bus.rsp_error   = error_q;
   assign bus.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_fact_arbiter.sv
// Bench for fact_arbiter: directed jobs against a transaction-level model of the
// arbiter plus an engine model with configurable latency, error, silence and hold.
module tb_fact_arbiter;
   localparam int unsigned To  = 8;
   localparam int          Lat = 6;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fact_arbiter_if bus ();

   fact_arbiter #(.TIMEOUT(To)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int cmp_pass = 0, cmp_total = 0, dir_pass = 0, dir_total = 0;

   bit          eng_mute  = 1'b0;
   int          eng_hold  = 0;
   logic [31:0] eng_err_n = 32'hffff_ffff;

   function automatic logic [31:0] fact(input logic [31:0] n);
      logic [31:0] p = 32'd1;
      for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
      return p;
   endfunction

   function automatic void cchk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_total++;
      if (act === exp) cmp_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endfunction

   function automatic void dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
      dir_total++;
      if (act === exp) dir_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endfunction

   // Engine: answers Lat cycles after go, holds done/error until go low plus eng_hold cycles.
   int eng_cnt, eng_hold_cnt;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         eng_cnt          <= 0;
         eng_hold_cnt     <= 0;
         bus.fact_done    <= 1'b0;
         bus.fact_error   <= 1'b0;
         bus.fact_product <= '0;
      end else if (bus.fact_go) begin
         if (!bus.fact_done && !bus.fact_error && !eng_mute) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt + 1 == Lat) begin
               bus.fact_product <= fact(bus.fact_n);
               if (bus.fact_n == eng_err_n) bus.fact_error <= 1'b1;
               else bus.fact_done <= 1'b1;
               eng_hold_cnt <= eng_hold;
            end
         end
      end else begin
         eng_cnt <= 0;
         if (eng_hold_cnt > 0) eng_hold_cnt <= eng_hold_cnt - 1;
         else begin
            bus.fact_done  <= 1'b0;
            bus.fact_error <= 1'b0;
         end
      end
   end

   // Transaction model: job phases, expected latency and result per accepted job.
   typedef enum logic [1:0] {PhFree, PhRun, PhResp, PhDrain} phase_e;
   phase_e      ph = PhFree;
   int          age, exp_lat;
   bit          m_owner, m_last = 1'b1;
   logic [31:0] m_n = '0, m_prod = '0, p_prod = '0;
   bit          m_err, m_to, p_err, p_to;

   always @(negedge clk) begin : cmp
      logic [1:0] vld, rdy, rv, exp_rdy, exp_rv;
      vld = {bus.req1_valid, bus.req0_valid};
      rdy = {bus.req1_ready, bus.req0_ready};
      rv  = {bus.rsp1_valid, bus.rsp0_valid};
      if (!reset) begin
         ph = PhFree; m_last = 1'b1; m_n = '0; m_prod = '0; m_err = 1'b0; m_to = 1'b0;
         cchk("rst_ready", 32'(rdy), 0);
         cchk("rst_busy", 32'(bus.busy), 0);
         cchk("rst_go", 32'(bus.fact_go), 0);
         cchk("rst_rsp_valid", 32'(rv), 0);
         cchk("rst_fact_n", bus.fact_n, 0);
         cchk("rst_product", bus.rsp_product, 0);
         cchk("rst_error", 32'(bus.rsp_error), 0);
         cchk("rst_timeout", 32'(bus.rsp_timeout), 0);
      end else begin
         if (ph == PhRun) begin
            age++;
            if (age == exp_lat) begin
               ph = PhResp; m_prod = p_prod; m_err = p_err; m_to = p_to;
            end
         end
         exp_rdy = 2'b00;
         if (ph == PhFree) exp_rdy = (vld == 2'b11) ? (m_last ? 2'b01 : 2'b10) : vld;
         exp_rv = (ph == PhResp) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
         cchk("req_ready", 32'(rdy), 32'(exp_rdy));
         cchk("rsp_valid", 32'(rv), 32'(exp_rv));
         cchk("fact_go", 32'(bus.fact_go), 32'(ph == PhRun));
         cchk("busy", 32'(bus.busy), 32'(ph != PhFree));
         cchk("fact_n", bus.fact_n, m_n);
         cchk("rsp_product", bus.rsp_product, m_prod);
         cchk("rsp_error", 32'(bus.rsp_error), 32'(m_err));
         cchk("rsp_timeout", 32'(bus.rsp_timeout), 32'(m_to));
         case (ph)
            PhFree: if ((exp_rdy & vld) != 2'b00) begin
               m_owner = exp_rdy[1];
               m_last  = m_owner;
               m_n     = m_owner ? bus.req1_n : bus.req0_n;
               if (eng_mute) begin
                  p_prod = '0; p_err = 1'b1; p_to = 1'b1; exp_lat = To + 1;
               end else begin
                  p_prod = fact(m_n); p_err = (m_n == eng_err_n); p_to = 1'b0; exp_lat = Lat + 2;
               end
               age = 0;
               ph  = PhRun;
            end
            PhResp:  if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) ph = PhDrain;
            PhDrain: if (!bus.fact_done && !bus.fact_error) ph = PhFree;
            default: ;
         endcase
      end
   end

   task automatic accept(input bit who, input logic [31:0] n);
      bit ok = 1'b0;
      if (who) begin bus.req1_valid = 1'b1; bus.req1_n = n; end
      else begin bus.req0_valid = 1'b1; bus.req0_n = n; end
      for (int i = 0; i < 100 && !ok; i++) begin
         #1;
         if (who ? bus.req1_ready : bus.req0_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      if (!ok) dchk("accept_wait", 32'(who ? bus.req1_ready : bus.req0_ready), 1);
      if (who) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
   endtask

   task automatic collect(input bit who, output logic [31:0] prod, output bit err,
                          output bit to, output bit other);
      bit got = 1'b0;
      prod = '0; err = 1'b0; to = 1'b0; other = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         #1;
         if (who ? bus.rsp1_valid : bus.rsp0_valid) begin
            got   = 1'b1;
            prod  = bus.rsp_product;
            err   = bus.rsp_error;
            to    = bus.rsp_timeout;
            other = who ? bus.rsp0_valid : bus.rsp1_valid;
            if (who) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      if (!got) dchk("rsp_wait", 32'(who ? bus.rsp1_valid : bus.rsp0_valid), 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && bus.busy; i++) begin @(posedge clk); #1; end
      if (bus.busy) dchk("idle_wait", 32'(bus.busy), 0);
   endtask

   initial begin
      logic [31:0] p;
      bit e, t, o;
      int bad_rdy, bad_go, bad_prod, bad_rv;
      bus.req0_valid = 1'b1; bus.req0_n = 32'd3;
      bus.req1_valid = 1'b1; bus.req1_n = 32'd4;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
      #1 reset = 1'b0;
      #6;
      dchk("ready_in_reset", 32'({bus.req1_ready, bus.req0_ready}), 0);
      dchk("busy_in_reset", 32'(bus.busy), 0);
      @(posedge clk); #1 reset = 1'b1;
      #1;
      dchk("tie1_req0_ready", 32'(bus.req0_ready), 1);
      dchk("tie1_req1_ready", 32'(bus.req1_ready), 0);

      // Tie from reset: req0 (3! = 6) then req1 (4! = 24).
      accept(0, 32'd3);
      collect(0, p, e, t, o);
      dchk("a_prod", p, 6); dchk("a_err", 32'(e), 0); dchk("a_other", 32'(o), 0);
      accept(1, 32'd4);
      collect(1, p, e, t, o);
      dchk("b_prod", p, 24);
      wait_idle();
      bus.req0_valid = 1'b1; bus.req0_n = 32'd5;
      bus.req1_valid = 1'b1; bus.req1_n = 32'd2;
      #1;
      dchk("tie2_req0_ready", 32'(bus.req0_ready), 1);
      dchk("tie2_req1_ready", 32'(bus.req1_ready), 0);
      accept(0, 32'd5);
      collect(0, p, e, t, o);
      dchk("c_prod", p, 120); dchk("c_err", 32'(e), 0); dchk("c_to", 32'(t), 0);
      accept(1, 32'd2);
      collect(1, p, e, t, o);
      dchk("d_prod", p, 2);
      wait_idle();

      // Engine error; product still latched (13! mod 2^32).
      eng_err_n = 32'd13;
      accept(1, 32'd13);
      collect(1, p, e, t, o);
      dchk("err_prod", p, 32'd1932053504); dchk("err_err", 32'(e), 1);
      dchk("err_to", 32'(t), 0); dchk("err_other", 32'(o), 0);
      wait_idle();
      eng_err_n = 32'hffff_ffff;

      // Silent engine: watchdog response.
      eng_mute = 1'b1;
      accept(0, 32'd7);
      collect(0, p, e, t, o);
      dchk("to_prod", p, 0); dchk("to_err", 32'(e), 1); dchk("to_to", 32'(t), 1);
      dchk("to_drain_busy", 32'(bus.busy), 1);
      @(posedge clk); #1;
      dchk("to_idle", 32'(bus.busy), 0);
      eng_mute = 1'b0;

      // Slow consumer with a competing requester and a lingering done.
      eng_hold = 30;
      accept(0, 32'd4);
      for (int i = 0; i < 100 && !bus.rsp0_valid; i++) begin @(posedge clk); #1; end
      dchk("hold_rsp", 32'(bus.rsp0_valid), 1);
      bus.req1_valid = 1'b1; bus.req1_n = 32'd3;
      bad_rdy = 0; bad_go = 0; bad_prod = 0; bad_rv = 0;
      repeat (20) begin
         #1;
         if (bus.req1_ready) bad_rdy++;
         if (bus.fact_go) bad_go++;
         if (bus.rsp_product != 32'd24) bad_prod++;
         if (!bus.rsp0_valid) bad_rv++;
         @(posedge clk); #1;
      end
      dchk("hold_req1_ready", 32'(bad_rdy), 0); dchk("hold_go", 32'(bad_go), 0);
      dchk("hold_prod", 32'(bad_prod), 0); dchk("hold_rsp_valid", 32'(bad_rv), 0);
      collect(0, p, e, t, o);
      eng_hold = 0;
      dchk("hold_collect", p, 24);
      dchk("drain_wait0", 32'(bus.busy), 1);
      @(posedge clk); #1;
      dchk("drain_wait1", 32'(bus.busy), 1);
      wait_idle();
      accept(1, 32'd3);
      collect(1, p, e, t, o);
      dchk("after_drain_prod", p, 6);
      wait_idle();

      // Reset mid-run after a req0 grant: next tie must still favour req0.
      accept(0, 32'd6);
      @(posedge clk); #1;
      dchk("rr_go", 32'(bus.fact_go), 1);
      #2 reset = 1'b0;
      #1;
      dchk("rr_go_async", 32'(bus.fact_go), 0);
      dchk("rr_busy_async", 32'(bus.busy), 0);
      dchk("rr_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
      bus.req0_valid = 1'b1; bus.req0_n = 32'd2;
      bus.req1_valid = 1'b1; bus.req1_n = 32'd1;
      @(posedge clk); #1 reset = 1'b1;
      #1;
      dchk("tie3_req0_ready", 32'(bus.req0_ready), 1);
      dchk("tie3_req1_ready", 32'(bus.req1_ready), 0);
      accept(0, 32'd2);
      collect(0, p, e, t, o);
      dchk("rr_prod0", p, 2);
      accept(1, 32'd1);
      collect(1, p, e, t, o);
      dchk("rr_prod1", p, 1);
      wait_idle();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", cmp_pass + dir_pass, cmp_total + dir_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed",
               cmp_pass + dir_pass, cmp_total + dir_total);
      $fatal(1, "watchdog expired");
   end
endmodule
